// File: rtl/s2mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : s2mm_pkg
//  Description : Shared types and constants for the s2mm stream-to-memory
//                datamover: FSM state encoding, AXI burst/response codes,
//                4 KB page size and the beat-size derivation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package s2mm_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [12:0] BOUNDARY_4K    = 13'd4096;

    // log2 of the number of bytes carried by one data beat (AxSIZE encoding)
    function automatic int unsigned s2mm_size(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/s2mm_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : s2mm_burst_calc
//  Description : Combinational burst length: the smallest of the remaining
//                beats, the maximum burst length and the beats left before
//                the next 4 KB page boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module s2mm_burst_calc #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic [31:0] rem_beats_i,
    input  logic [11:0] addr_lo_i,
    output logic [8:0]  len_o
);
    import s2mm_pkg::*;

    localparam int SIZE = s2mm_size(DATA_WIDTH);

    logic [12:0] w_room_bytes;
    logic [12:0] w_room_beats;

    // Addresses are beat aligned, so the room to the page end is never zero.
    always_comb begin
        w_room_bytes = BOUNDARY_4K - {1'b0, addr_lo_i};
        w_room_beats = w_room_bytes >> SIZE;
        len_o        = 9'(MAX_BURST);
        if (rem_beats_i < 32'(MAX_BURST)) begin
            len_o = rem_beats_i[8:0];
        end
        if ({4'd0, len_o} > w_room_beats) begin
            len_o = w_room_beats[8:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/s2mm_datamover.sv
`default_nettype none
// ============================================================================
//  Module      : s2mm_datamover
//  Description : Drains an AXI4-Stream into memory over the AW/W/B channels
//                of an AXI4 master. One INCR burst in flight at a time, no
//                burst crosses a 4 KB page. Early TLAST pads the open burst.
//  Revision    : 1.0 - initial release
// ============================================================================
module s2mm_datamover #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_ready,
    output logic                      ap_idle,
    input  logic [63:0]               mem_V,
    input  logic [31:0]               size_V,
    input  logic [7:0]                tdest_V,
    output logic [7:0]                tid_V,
    output logic                      tid_V_ap_vld,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [7:0]                s_axis_tid,
    input  logic [7:0]                s_axis_tdest,
    input  logic                      s_axis_tlast,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready
);
    import s2mm_pkg::*;

    localparam int SIZE = s2mm_size(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           rem_q, rem_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  tlast_seen_q, tlast_seen_d;
    logic                  first_beat_q, first_beat_d;
    logic [7:0]            tid_q, tid_d;
    logic                  tid_vld_q, tid_vld_d;
    logic                  ready_q, ready_d;

    logic [8:0]            w_calc_len;
    logic [8:0]            w_len_m1;
    logic                  w_match;
    logic                  w_beat;
    logic                  w_bresp_ok_unused;

    s2mm_burst_calc #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) u_burst_calc (
        .rem_beats_i (rem_q),
        .addr_lo_i   (addr_q[11:0]),
        .len_o       (w_calc_len)
    );

    // Error responses are tolerated: BRESP is observed but never steers the transfer.
    assign w_bresp_ok_unused = (m_axi_bresp == AXI_RESP_OKAY);
    assign w_len_m1          = len_q - 9'd1;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = w_len_m1[7:0];
    assign m_axi_awsize  = 3'(SIZE);
    assign m_axi_awburst = AXI_BURST_INCR;
    assign ap_idle       = (state_q == S_IDLE);
    assign ap_done       = (state_q == S_DONE);
    assign ap_ready      = ready_q;
    assign tid_V         = tid_q;
    assign tid_V_ap_vld  = tid_vld_q;

    // State and datapath registers; synchronous reset abandons any open bus activity.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            tlast_seen_q <= 1'b0;
            first_beat_q <= 1'b0;
            tid_q        <= '0;
            tid_vld_q    <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            tlast_seen_q <= tlast_seen_d;
            first_beat_q <= first_beat_d;
            tid_q        <= tid_d;
            tid_vld_q    <= tid_vld_d;
            ready_q      <= ready_d;
        end
    end

    // Next-state logic and channel handshakes for the command/burst sequence.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        tlast_seen_d  = tlast_seen_q;
        first_beat_d  = first_beat_q;
        tid_d         = tid_q;
        tid_vld_d     = 1'b0;
        ready_d       = 1'b0;
        w_match       = 1'b0;
        w_beat        = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        s_axis_tready = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    addr_d       = mem_V[ADDR_WIDTH-1:0];
                    rem_d        = size_V >> SIZE;
                    tlast_seen_d = 1'b0;
                    first_beat_d = 1'b0;
                    ready_d      = 1'b1;
                    state_d      = S_CALC;
                end
            end
            S_CALC: begin
                if (rem_q == 32'd0 || tlast_seen_q) begin
                    state_d = S_DONE;
                end else begin
                    len_d   = w_calc_len;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                m_axi_wlast = (cnt_q == w_len_m1);
                if (tlast_seen_q) begin
                    // Packet ended early: fill the open burst with null-strobe beats.
                    m_axi_wvalid = 1'b1;
                    w_beat       = m_axi_wready;
                end else begin
                    // Beats for another destination are swallowed without a write.
                    w_match       = (s_axis_tdest == tdest_V);
                    m_axi_wvalid  = s_axis_tvalid & w_match;
                    s_axis_tready = w_match ? m_axi_wready : 1'b1;
                    m_axi_wdata   = s_axis_tdata;
                    m_axi_wstrb   = '1;
                    w_beat        = m_axi_wvalid & m_axi_wready;
                    if (w_beat) begin
                        if (!first_beat_q) begin
                            first_beat_d = 1'b1;
                            tid_d        = s_axis_tid;
                            tid_vld_d    = 1'b1;
                        end
                        if (s_axis_tlast) begin
                            tlast_seen_d = 1'b1;
                        end
                    end
                end
                if (w_beat) begin
                    rem_d = rem_q - 32'd1;
                    cnt_d = cnt_q + 9'd1;
                    if (m_axi_wlast) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    addr_d  = addr_q + (ADDR_WIDTH'(len_q) << SIZE);
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_s2mm_datamover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_s2mm_datamover
//  Description : Scoreboard bench for s2mm_datamover. A reference model turns
//                each command plus the pending stream into the expected AW,
//                W and TID sequences; a monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_s2mm_datamover;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  tid;
        logic [7:0]  dest;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        pad;
    } wexp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } awexp_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_ready, ap_idle;
    logic [63:0] mem_V = '0;
    logic [31:0] size_V = '0;
    logic [7:0]  tdest_V = '0;
    logic [7:0]  tid_V;
    logic        tid_V_ap_vld;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  s_axis_tid = '0;
    logic [7:0]  s_axis_tdest = '0;
    logic        s_axis_tlast = 1'b0;
    logic [63:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;

    always #5 ACLK = ~ACLK;

    s2mm_datamover #(
        .DATA_WIDTH (64),
        .MAX_BURST  (16),
        .ADDR_WIDTH (64)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_ready      (ap_ready),
        .ap_idle       (ap_idle),
        .mem_V         (mem_V),
        .size_V        (size_V),
        .tdest_V       (tdest_V),
        .tid_V         (tid_V),
        .tid_V_ap_vld  (tid_V_ap_vld),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tlast  (s_axis_tlast),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_b_cyc = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;
    bit pend_b = 1'b0;

    beat_t       drv_q[$];
    beat_t       mdl_q[$];
    wexp_t       exp_w[$];
    awexp_t      exp_aw[$];
    logic [7:0]  exp_tid[$];

    always @(posedge ACLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (no expectation or timeout)", name);
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] id,
                             input logic [7:0] dst, input logic lst);
        beat_t b;
        b.data = d; b.tid = id; b.dest = dst; b.last = lst;
        drv_q.push_back(b);
        mdl_q.push_back(b);
    endtask

    // Reference model: split the command into page-safe bursts, walk the
    // pending stream for beats of the selected destination, then emit the
    // bursts that were actually opened, padding the last one after TLAST.
    task automatic predict(input logic [63:0] a, input logic [31:0] sz, input logic [7:0] d,
                           output int nburst);
        int n, r, l, room, total, cnt;
        bit tl;
        logic [63:0] cur;
        logic [63:0] ba[$];
        int blen[$];
        int bend[$];
        logic [63:0] dq[$];
        beat_t b;
        wexp_t w;
        awexp_t aw;
        n = int'(sz / 8);
        cur = a; r = n; total = 0;
        while (r > 0) begin
            room = (4096 - int'(cur[11:0])) / 8;
            l = (r < 16) ? r : 16;
            if (l > room) l = room;
            ba.push_back(cur); blen.push_back(l);
            total += l; bend.push_back(total);
            cur += 64'(l * 8); r -= l;
        end
        cnt = 0; tl = 1'b0;
        while (cnt < n && !tl && mdl_q.size() > 0) begin
            b = mdl_q.pop_front();
            if (b.dest == d) begin
                if (cnt == 0) exp_tid.push_back(b.tid);
                dq.push_back(b.data);
                cnt++;
                if (b.last) tl = 1'b1;
            end
        end
        total = 0; nburst = 0;
        foreach (ba[k]) begin
            if (bend[k] - blen[k] < cnt) begin
                aw.addr = ba[k]; aw.len = 8'(blen[k] - 1);
                exp_aw.push_back(aw);
                total = bend[k];
                nburst++;
            end
        end
        for (int i = 0; i < total; i++) begin
            w.pad  = (i >= cnt);
            w.data = w.pad ? 64'd0 : dq[i];
            w.strb = w.pad ? 8'h00 : 8'hFF;
            w.last = 1'b0;
            foreach (bend[k]) if (bend[k] == i + 1) w.last = 1'b1;
            exp_w.push_back(w);
        end
    endtask

    // Random stream for a command: enough beats for the selected destination,
    // with foreign-destination beats and occasional early TLAST mixed in.
    task automatic gen_for(input int n, input logic [7:0] d);
        int have;
        logic [7:0] bd;
        have = 0;
        foreach (mdl_q[k]) if (mdl_q[k].dest == d) have++;
        while (have < n) begin
            bd = ($urandom_range(0, 4) == 0) ? (d ^ 8'h01) : d;
            push_beat({$urandom, $urandom}, 8'($urandom), bd,
                      (bd == d) && ($urandom_range(0, 31) == 0));
            if (bd == d) have++;
        end
    endtask

    task automatic run_cmd(input logic [63:0] a, input logic [31:0] sz,
                           input logic [7:0] d, input string tag);
        int nbur, r0, d0, t;
        bit seen, tr_ok;
        predict(a, sz, d, nbur);
        r0 = rdy_cnt; d0 = done_cnt;
        @(negedge ACLK);
        mem_V = a; size_V = sz; tdest_V = d; ap_start = 1'b1;
        @(negedge ACLK);
        chk({tag, "_ap_ready"}, 128'(ap_ready), 128'd1);
        ap_start = 1'b0;
        @(negedge ACLK);
        if (nbur > 0) chk({tag, "_aw_latency"}, 128'(m_axi_awvalid), 128'd1);
        else          chk({tag, "_zero_done"}, 128'(ap_done), 128'd1);
        seen = ap_done; t = 0; tr_ok = 1'b1;
        while (!seen && t < 20000) begin
            @(negedge ACLK);
            t++;
            seen = ap_done;
        end
        if (!seen) fail_now({tag, "_done_timeout"});
        if (nbur > 0) chk({tag, "_done_latency"}, 128'(cyc - last_b_cyc), 128'd2);
        @(negedge ACLK);
        if (nbur == 0 && s_axis_tready) tr_ok = 1'b0;
        if (nbur == 0) chk({tag, "_tready_low"}, 128'(tr_ok), 128'd1);
        chk({tag, "_aw_left"},   128'(exp_aw.size()), 128'd0);
        chk({tag, "_w_left"},    128'(exp_w.size()), 128'd0);
        chk({tag, "_tid_left"},  128'(exp_tid.size()), 128'd0);
        chk({tag, "_ready_cnt"}, 128'(rdy_cnt - r0), 128'd1);
        chk({tag, "_done_cnt"},  128'(done_cnt - d0), 128'd1);
        chk({tag, "_idle"},      128'(ap_idle), 128'd1);
    endtask

    // Bus partner: sample handshakes between edges, drive stalls after the edge.
    initial begin : bus
        bit s_hs, b_hs, wl_hs;
        forever begin
            @(negedge ACLK);
            s_hs  = s_axis_tvalid && s_axis_tready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            wl_hs = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            @(posedge ACLK);
            #1;
            if (s_hs && drv_q.size() > 0) void'(drv_q.pop_front());
            if (b_hs)  pend_b = 1'b0;
            if (wl_hs) pend_b = 1'b1;
            m_axi_awready = ($urandom_range(0, 3) != 0);
            m_axi_wready  = ($urandom_range(0, 3) != 0);
            m_axi_bvalid  = pend_b && ($urandom_range(0, 2) != 0);
            m_axi_bresp   = 2'($urandom);
            if (drv_q.size() > 0 && ((s_axis_tvalid && !s_hs) || $urandom_range(0, 3) != 0)) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = drv_q[0].data;
                s_axis_tid    = drv_q[0].tid;
                s_axis_tdest  = drv_q[0].dest;
                s_axis_tlast  = drv_q[0].last;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: pop and compare whenever the DUT completes a transfer.
    always @(negedge ACLK) begin
        awexp_t ea;
        wexp_t  ew;
        if (!ARESET) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_aw.size() == 0) fail_now("aw_unexpected");
                else begin
                    ea = exp_aw.pop_front();
                    chk("aw_addr",  128'(m_axi_awaddr), 128'(ea.addr));
                    chk("aw_len",   128'(m_axi_awlen), 128'(ea.len));
                    chk("aw_size",  128'(m_axi_awsize), 128'd3);
                    chk("aw_burst", 128'(m_axi_awburst), 128'd1);
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_w.size() == 0) fail_now("w_unexpected");
                else begin
                    ew = exp_w.pop_front();
                    chk("w_data", 128'(m_axi_wdata), 128'(ew.data));
                    chk("w_strb", 128'(m_axi_wstrb), 128'(ew.strb));
                    chk("w_last", 128'(m_axi_wlast), 128'(ew.last));
                    if (ew.pad) chk("pad_tready", 128'(s_axis_tready), 128'd0);
                end
            end
            if (m_axi_bvalid && m_axi_bready) last_b_cyc = cyc;
            if (tid_V_ap_vld) begin
                if (exp_tid.size() == 0) fail_now("tid_unexpected");
                else chk("tid_value", 128'(tid_V), 128'(exp_tid.pop_front()));
            end
            if (ap_ready) rdy_cnt++;
            if (ap_done)  done_cnt++;
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] a;
        logic [31:0] sz;
        logic [7:0]  d;
        int t;
        repeat (3) @(negedge ACLK);
        chk("rst_idle",    128'(ap_idle), 128'd1);
        chk("rst_awvalid", 128'(m_axi_awvalid), 128'd0);
        chk("rst_wvalid",  128'(m_axi_wvalid), 128'd0);
        chk("rst_tready",  128'(s_axis_tready), 128'd0);
        chk("rst_bready",  128'(m_axi_bready), 128'd0);
        chk("rst_pulses",  128'({ap_done, ap_ready, tid_V_ap_vld}), 128'd0);
        chk("rst_tid",     128'(tid_V), 128'd0);
        ARESET = 1'b0;

        // Two full bursts, TLAST on the final beat.
        for (int i = 0; i < 32; i++) push_beat({32'hB0B0_0000, 32'(i)}, 8'h10, 8'h00, i == 31);
        run_cmd(64'h1000_0000, 32'd256, 8'h00, "basic");

        // Transfer straddling a 4 KB page.
        for (int i = 0; i < 16; i++) push_beat({$urandom, $urandom}, 8'h20, 8'h00, i == 15);
        run_cmd(64'h0000_0FC0, 32'd128, 8'h00, "split4k");

        // TLAST on beat 4 of a 32-beat command.
        for (int i = 0; i < 4; i++) push_beat({$urandom, $urandom}, 8'h30, 8'h00, i == 3);
        run_cmd(64'h0000_2000, 32'd256, 8'h00, "early");

        // Zero-size command leaves pending beats for the next one.
        for (int i = 0; i < 3; i++) push_beat({$urandom, $urandom}, 8'h40, 8'h00, 1'b0);
        run_cmd(64'h0000_3000, 32'd0, 8'h00, "zero");
        run_cmd(64'h0000_3000, 32'd29, 8'h00, "leftover");

        // Destination filtering and TID capture.
        push_beat(64'hDEAD_0001, 8'h11, 8'h01, 1'b0);
        push_beat(64'hCAFE_0001, 8'h5A, 8'h03, 1'b0);
        push_beat(64'hCAFE_0002, 8'h5B, 8'h03, 1'b0);
        push_beat(64'hDEAD_0002, 8'h12, 8'h01, 1'b0);
        push_beat(64'hCAFE_0003, 8'h5C, 8'h03, 1'b0);
        push_beat(64'hCAFE_0004, 8'h5D, 8'h03, 1'b1);
        run_cmd(64'h0000_4000, 32'd64, 8'h03, "tdest");
        chk("tdest_tid_hold", 128'(tid_V), 128'h5A);

        // Randomized commands under random bus stalls.
        for (int k = 0; k < 20; k++) begin
            d  = 8'($urandom_range(0, 3));
            sz = 32'($urandom_range(0, 1200));
            a  = 64'h8000_0000 + 64'($urandom_range(0, 15)) * 64'd4096;
            if ($urandom_range(0, 1) == 1) a = a + 64'd4096 - 64'(8 * $urandom_range(1, 40));
            else                           a = a + 64'(8 * $urandom_range(0, 511));
            gen_for(int'(sz / 8), d);
            run_cmd(a, sz, d, "rand");
        end

        // Reset while a burst is streaming.
        for (int i = 0; i < 40; i++) push_beat({$urandom, $urandom}, 8'h77, 8'h00, 1'b0);
        mem_V = 64'h0000_5000; size_V = 32'd320; tdest_V = 8'h00;
        begin
            int nb;
            predict(64'h0000_5000, 32'd320, 8'h00, nb);
        end
        @(negedge ACLK);
        ap_start = 1'b1;
        @(negedge ACLK);
        ap_start = 1'b0;
        t = 0;
        while (!m_axi_wvalid && t < 2000) begin
            @(negedge ACLK);
            t++;
        end
        if (!m_axi_wvalid) fail_now("rst_reach_data");
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("midrst_idle",    128'(ap_idle), 128'd1);
        chk("midrst_valids",  128'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}), 128'd0);
        chk("midrst_pulses",  128'({ap_done, tid_V_ap_vld}), 128'd0);
        ARESET = 1'b0;
        exp_aw.delete(); exp_w.delete(); exp_tid.delete();
        drv_q.delete(); mdl_q.delete();
        pend_b = 1'b0;
        repeat (4) @(negedge ACLK);
        chk("post_rst_idle", 128'(ap_idle), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/s2mm_datamover.md
Name: s2mm_datamover

Overview:
- Datapath core of the s2mm kernel. Consumes the ap_start/mem_V/size_V/tdest_V controls driven by the AXI-lite control slave, and returns ap_done/ap_ready/ap_idle/tid_V to it.
- Drains an AXI4-Stream into memory through an AXI4 master write channel (AW/W/B only).
- Issues INCR bursts, one burst outstanding at a time; no burst crosses a 4 KB boundary.

Parameters:
DATA_WIDTH, 64, stream and AXI data width in bits (32/64/128)
MAX_BURST, 16, maximum beats per burst (power of 2, ≤256)
ADDR_WIDTH, 64, AXI address width

Ports:
ACLK  in  1  clock
ARESET  in  1  reset
ap_start  in  1  level start from control slave
ap_done  out  1  one-cycle pulse, transfer complete
ap_ready  out  1  one-cycle pulse, command arguments latched
ap_idle  out  1  high while in IDLE
mem_V  in  64  destination byte address, DATA_WIDTH/8 aligned
size_V  in  32  transfer size in bytes
tdest_V  in  8  accepted stream TDEST
tid_V  out  8  TID of first accepted beat
tid_V_ap_vld  out  1  one-cycle strobe qualifying tid_V
s_axis_tdata  in  DATA_WIDTH  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready
s_axis_tid  in  8  stream TID
s_axis_tdest  in  8  stream TDEST
s_axis_tlast  in  1  end of packet
m_axi_awaddr  out  ADDR_WIDTH  burst address
m_axi_awlen  out  8  beats-1
m_axi_awsize  out  3  log2(DATA_WIDTH/8), constant
m_axi_awburst  out  2  constant 2'b01 (INCR)
m_axi_awvalid  out  1  address valid
m_axi_awready  in  1  address ready
m_axi_wdata  out  DATA_WIDTH  write data
m_axi_wstrb  out  DATA_WIDTH/8  byte strobes
m_axi_wlast  out  1  last beat of burst
m_axi_wvalid  out  1  write valid
m_axi_wready  in  1  write ready
m_axi_bresp  in  2  write response
m_axi_bvalid  in  1  response valid
m_axi_bready  out  1  response ready

Behaviour:
- Reset: ACLK, ARESET synchronous active-high.
  - All valid/ready/pulse outputs are 0; ap_idle=1; tid_V=0.
  - FSM goes to IDLE; counters are cleared; address/len registers are 0.
- States: IDLE, CALC, ADDR, DATA, RESP, DONE.
- IDLE: ap_idle=1. On ap_start=1:
  - Latch addr=mem_V and rem_beats=size_V>>log2(BYTES). Sub-beat remainder bytes are dropped.
  - Clear the tlast_seen and first_beat flags; pulse ap_ready for 1 cycle; go to CALC.
- CALC, 1 cycle:
  - If rem_beats==0 or tlast_seen, go to DONE.
  - Else len=min(rem_beats, MAX_BURST, (4096-addr[11:0])/BYTES); go to ADDR.
- ADDR: awvalid=1, awaddr=addr, awlen=len-1. On awready, go to DATA with beat counter=0.
- DATA, normal beats (not tlast_seen):
  - wvalid = tvalid & (tdest==tdest_V); tready = wready; wdata=tdata; wstrb all ones.
  - A beat with tdest≠tdest_V has tready=1, wvalid=0 and is discarded (never counted).
  - On the first counted beat of the command: tid_V<=s_axis_tid and tid_V_ap_vld pulses once.
- DATA, padding (tlast_seen=1): remaining beats of the burst are emitted with wvalid=1, wstrb=0, wdata=0, tready=0.
- DATA, every counted beat: rem_beats--, counter++; wlast=(counter==len-1). An accepted TLAST sets tlast_seen. On the wlast handshake, go to RESP.
- RESP: bready=1. On bvalid: addr+=len*BYTES, then go to CALC.
  - Non-OKAY BRESP does not abort or alter the transfer.
- DONE: pulse ap_done for 1 cycle; go to IDLE.
  - ap_start still high in IDLE begins a new command the next cycle (auto-restart).
- Size exhausted before TLAST: tready=0 outside DATA; leftover stream beats stay for the next command.
- tready is 0 in every state except DATA.
- ARESET mid-burst: immediate return to IDLE; the bus is abandoned, with no completion of AW/W/B.
- Latency: ap_start to first awvalid is 2 cycles. Last bvalid to ap_done is 2 cycles.

Decomposition:
- Package s2mm_pkg: state enum, AXI_BURST_INCR, AXI_RESP_OKAY, the 4096 boundary constant, BYTES/SIZE derivation function.
- One sub-module, s2mm_burst_calc: combinational min(rem, MAX_BURST, 4K room), registered in CALC.

Test Plan:
- Basic: DATA_WIDTH=64, mem_V=0x1000_0000, size_V=256, TLAST on beat 32 → two AW with awlen=15 at 0x1000_0000 and 0x1000_0080; 32 full-strobe beats; one ap_ready; one ap_done.
- 4 KB split: mem_V=0xFC0, size_V=128 → AW 0xFC0 awlen=7, then AW 0x1000 awlen=7; data order preserved.
- Early TLAST: size_V=256, TLAST on beat 4 → first burst awlen=15, beats 5–16 have wstrb=0 and tready=0, no second AW, ap_done after the B response.
- Zero size: size_V=0 → ap_ready then ap_done; no awvalid; tready stays 0.
- TID/TDEST: tdest_V=3; a beat with tdest=1 is dropped, then the first beat with tdest=3, tid=0x5A → tid_V=0x5A with a single tid_V_ap_vld pulse; only tdest=3 data written.
- Backpressure and reset: random awready/wready/bvalid stalls give identical memory image; ARESET asserted in DATA → next cycle ap_idle=1 and all valids 0.
